// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline stages: control-bit packing,
// default memory geometry and the MEM-stage FSM encoding.
package mips_pkg;

   localparam int WB_REG_WRITE  = 1;
   localparam int WB_MEM_TO_REG = 0;

   localparam int M_BRANCH    = 2;
   localparam int M_MEM_READ  = 1;
   localparam int M_MEM_WRITE = 0;

   localparam int DEF_DEPTH  = 256;
   localparam int DEF_ADDR_W = 8;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } mem_state_t;

endpackage

// File: rtl/data_memory.sv
// Single-port word-addressed data memory: combinational read, synchronous write,
// so a read in the same cycle as a write returns the old word.
module data_memory
   import mips_pkg::*;
#(
   parameter int DEPTH  = DEF_DEPTH,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              clock,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata
);

   logic [31:0] mem [DEPTH];

   assign rdata = mem[addr];

   always_ff @(posedge clock) begin
      if (we) mem[addr] <= wdata;
   end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: data memory access with optional multi-cycle latency (stalling
// upstream), branch resolution back to IF, and the MEM/WB pipeline register.
module mem_stage
   import mips_pkg::*;
#(
   parameter int DEPTH       = DEF_DEPTH,
   parameter int ADDR_W      = DEF_ADDR_W,
   parameter int MEM_LATENCY = 0
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [1:0]  wb_in,
   input  logic        branch,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic        zero_flag,
   input  logic [31:0] alu_result,
   input  logic [31:0] write_data,
   input  logic [4:0]  write_back_reg,
   input  logic [31:0] pc_add,
   output logic        pc_src,
   output logic [31:0] branch_target,
   output logic        stall,
   output logic [1:0]  wb_out,
   output logic [31:0] mem_data_out,
   output logic [31:0] alu_result_out,
   output logic [4:0]  write_back_reg_out
);

   localparam int CNT_W = (MEM_LATENCY > 2) ? $clog2(MEM_LATENCY) : 1;
   localparam logic [CNT_W-1:0] CNT_INIT =
      (MEM_LATENCY > 0) ? CNT_W'(MEM_LATENCY - 1) : '0;

   mem_state_t       state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [2:0]       m_ctrl;
   logic             mem_op;
   logic             complete;
   logic             mem_we;
   logic [31:0]      rd_data;

   assign m_ctrl = {branch, mem_read, mem_write};
   assign mem_op = m_ctrl[M_MEM_READ] | m_ctrl[M_MEM_WRITE];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // complete marks the one cycle in which the access (if any) takes effect
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      complete  = 1'b0;
      case (state)
         IDLE: begin
            if (!mem_op || MEM_LATENCY == 0) begin
               complete = 1'b1;
            end else begin
               state_nxt = WAIT;
               cnt_nxt   = CNT_INIT;
            end
         end
         WAIT: begin
            if (cnt == '0) begin
               complete  = 1'b1;
               state_nxt = IDLE;
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Reset gating keeps stall low and drops any pending store while reset is held
   assign stall  = ~reset & ~complete;
   assign mem_we = m_ctrl[M_MEM_WRITE] & complete & ~reset;

   assign pc_src        = m_ctrl[M_BRANCH] & zero_flag & ~stall;
   assign branch_target = pc_add;

   data_memory #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_data_memory (
      .clock (clock),
      .we    (mem_we),
      .addr  (alu_result[ADDR_W+1:2]),
      .wdata (write_data),
      .rdata (rd_data)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wb_out             <= '0;
         mem_data_out       <= '0;
         alu_result_out     <= '0;
         write_back_reg_out <= '0;
      end else if (complete) begin
         wb_out[WB_REG_WRITE]  <= wb_in[WB_REG_WRITE];
         wb_out[WB_MEM_TO_REG] <= wb_in[WB_MEM_TO_REG];
         mem_data_out          <= m_ctrl[M_MEM_READ] ? rd_data : 32'h0;
         alu_result_out        <= alu_result;
         write_back_reg_out    <= write_back_reg;
      end else begin
         wb_out <= '0;
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: latency-0, latency-3 and latency-2 instances
// share one stimulus bus; each scenario checks only the instance it targets.
module tb_mem_stage;

   logic        clock = 1'b0;
   logic        reset;
   logic [1:0]  wb_in;
   logic        branch, mem_read, mem_write, zero_flag;
   logic [31:0] alu_result, write_data, pc_add;
   logic [4:0]  write_back_reg;

   logic        pc_src0, pc_src3, pc_src2;
   logic [31:0] bt0, bt3, bt2;
   logic        stall0, stall3, stall2;
   logic [1:0]  wbo0, wbo3, wbo2;
   logic [31:0] mdo0, mdo3, mdo2;
   logic [31:0] aluo0, aluo3, aluo2;
   logic [4:0]  rgo0, rgo3, rgo2;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clock = ~clock;

   mem_stage #(.MEM_LATENCY(0)) u_l0 (
      .clock(clock), .reset(reset), .wb_in(wb_in), .branch(branch),
      .mem_read(mem_read), .mem_write(mem_write), .zero_flag(zero_flag),
      .alu_result(alu_result), .write_data(write_data),
      .write_back_reg(write_back_reg), .pc_add(pc_add),
      .pc_src(pc_src0), .branch_target(bt0), .stall(stall0), .wb_out(wbo0),
      .mem_data_out(mdo0), .alu_result_out(aluo0), .write_back_reg_out(rgo0));

   mem_stage #(.MEM_LATENCY(3)) u_l3 (
      .clock(clock), .reset(reset), .wb_in(wb_in), .branch(branch),
      .mem_read(mem_read), .mem_write(mem_write), .zero_flag(zero_flag),
      .alu_result(alu_result), .write_data(write_data),
      .write_back_reg(write_back_reg), .pc_add(pc_add),
      .pc_src(pc_src3), .branch_target(bt3), .stall(stall3), .wb_out(wbo3),
      .mem_data_out(mdo3), .alu_result_out(aluo3), .write_back_reg_out(rgo3));

   mem_stage #(.MEM_LATENCY(2)) u_l2 (
      .clock(clock), .reset(reset), .wb_in(wb_in), .branch(branch),
      .mem_read(mem_read), .mem_write(mem_write), .zero_flag(zero_flag),
      .alu_result(alu_result), .write_data(write_data),
      .write_back_reg(write_back_reg), .pc_add(pc_add),
      .pc_src(pc_src2), .branch_target(bt2), .stall(stall2), .wb_out(wbo2),
      .mem_data_out(mdo2), .alu_result_out(aluo2), .write_back_reg_out(rgo2));

   typedef struct packed {
      logic [1:0]  wb;
      logic        br, mr, mw, zf;
      logic [31:0] alu, wd, pc;
      logic [4:0]  rg;
      logic        exp_pc_src;
      logic [1:0]  exp_wb;
      logic [31:0] exp_mdo;
   } vec_t;

   vec_t vecs [11];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic set_in(input logic [1:0] wb, input logic br, input logic mr,
                         input logic mw, input logic zf, input logic [31:0] alu,
                         input logic [31:0] wd, input logic [31:0] pc,
                         input logic [4:0] rg);
      wb_in = wb; branch = br; mem_read = mr; mem_write = mw; zero_flag = zf;
      alu_result = alu; write_data = wd; pc_add = pc; write_back_reg = rg;
   endtask

   task automatic set_noop();
      set_in(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   // Full 4-cycle transaction on the latency-3 instance
   task automatic op3(input logic mr, input logic mw, input logic [31:0] alu,
                      input logic [31:0] wd, input logic [1:0] wb, input logic [4:0] rg);
      set_in(wb, 1'b0, mr, mw, 1'b0, alu, wd, 32'h0, rg);
      repeat (4) tick();
      set_noop();
   endtask

   initial begin
      vecs[0]  = '{2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 32'h1234, 32'h0,        32'h0,  5'd5, 1'b0, 2'b10, 32'h0};
      vecs[1]  = '{2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 32'h10,   32'hDEADBEEF, 32'h0,  5'd0, 1'b0, 2'b00, 32'h0};
      vecs[2]  = '{2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 32'h10,   32'h0,        32'h0,  5'd7, 1'b0, 2'b11, 32'hDEADBEEF};
      vecs[3]  = '{2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 32'h13,   32'h0,        32'h0,  5'd8, 1'b0, 2'b11, 32'hDEADBEEF};
      vecs[4]  = '{2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 32'h410,  32'h0,        32'h0,  5'd9, 1'b0, 2'b11, 32'hDEADBEEF};
      vecs[5]  = '{2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0,    32'h0,        32'h40, 5'd0, 1'b1, 2'b00, 32'h0};
      vecs[6]  = '{2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,    32'h0,        32'h44, 5'd0, 1'b0, 2'b00, 32'h0};
      vecs[7]  = '{2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 32'h30,   32'h1,        32'h0,  5'd0, 1'b0, 2'b00, 32'h0};
      vecs[8]  = '{2'b11, 1'b0, 1'b1, 1'b1, 1'b0, 32'h30,   32'h2,        32'h0,  5'd3, 1'b0, 2'b11, 32'h1};
      vecs[9]  = '{2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 32'h30,   32'h0,        32'h0,  5'd4, 1'b0, 2'b11, 32'h2};
      vecs[10] = '{2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 32'h30,   32'h0,        32'h0,  5'd6, 1'b0, 2'b10, 32'h0};

      set_noop();
      do_reset();

      // No-op passes through, then an asynchronous reset mid-cycle clears everything
      set_in(2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 32'h1234, 32'h0, 32'h0, 5'd5);
      #1 chk("noop_stall", {31'h0, stall0}, 32'h0);
      tick();
      chk("noop_wb_out", {30'h0, wbo0}, 32'h2);
      chk("noop_alu_out", aluo0, 32'h1234);
      #3 reset = 1'b1;
      #1;
      chk("rst_wb_out", {30'h0, wbo0}, 32'h0);
      chk("rst_alu_out", aluo0, 32'h0);
      chk("rst_reg_out", {27'h0, rgo0}, 32'h0);
      chk("rst_mdo", mdo0, 32'h0);
      chk("rst_stall3", {31'h0, stall3}, 32'h0);
      tick();
      reset = 1'b0;

      // Latency-0 table
      for (int i = 0; i < 11; i++) begin
         set_in(vecs[i].wb, vecs[i].br, vecs[i].mr, vecs[i].mw, vecs[i].zf,
                vecs[i].alu, vecs[i].wd, vecs[i].pc, vecs[i].rg);
         #1;
         chk($sformatf("v%0d_pc_src", i), {31'h0, pc_src0}, {31'h0, vecs[i].exp_pc_src});
         chk($sformatf("v%0d_branch_target", i), bt0, vecs[i].pc);
         chk($sformatf("v%0d_stall", i), {31'h0, stall0}, 32'h0);
         tick();
         chk($sformatf("v%0d_wb_out", i), {30'h0, wbo0}, {30'h0, vecs[i].exp_wb});
         chk($sformatf("v%0d_mdo", i), mdo0, vecs[i].exp_mdo);
         chk($sformatf("v%0d_alu_out", i), aluo0, vecs[i].alu);
         chk($sformatf("v%0d_reg_out", i), {27'h0, rgo0}, {27'h0, vecs[i].rg});
      end

      // Latency-3 load: three stall cycles with bubbles, data on the 4th edge
      set_noop();
      do_reset();
      op3(1'b0, 1'b1, 32'h8, 32'h55AA55AA, 2'b00, 5'd0);
      set_in(2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 32'h8, 32'h0, 32'h0, 5'd9);
      for (int c = 0; c < 4; c++) begin
         #1 chk($sformatf("l3_stall_c%0d", c), {31'h0, stall3}, (c < 3) ? 32'h1 : 32'h0);
         @(posedge clock);
         #1;
         if (c < 3) chk($sformatf("l3_bubble_c%0d", c), {30'h0, wbo3}, 32'h0);
      end
      chk("l3_load_data", mdo3, 32'h55AA55AA);
      chk("l3_load_wb", {30'h0, wbo3}, 32'h3);
      chk("l3_load_reg", {27'h0, rgo3}, 32'd9);
      set_noop();
      #1 chk("l3_stall_after", {31'h0, stall3}, 32'h0);

      // Reset during WAIT discards the pending store
      op3(1'b0, 1'b1, 32'h20, 32'h11111111, 2'b00, 5'd0);
      set_in(2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 32'h20, 32'h0000CAFE, 32'h0, 5'd0);
      #1 chk("abort_stall_c0", {31'h0, stall3}, 32'h1);
      tick();
      chk("abort_stall_c1", {31'h0, stall3}, 32'h1);
      #3 reset = 1'b1;
      #1 chk("abort_stall_rst", {31'h0, stall3}, 32'h0);
      set_noop();
      tick();
      reset = 1'b0;
      op3(1'b1, 1'b0, 32'h20, 32'h0, 2'b11, 5'd2);
      chk("abort_load_old", mdo3, 32'h11111111);
      chk("abort_load_wb", {30'h0, wbo3}, 32'h3);

      // Latency-2 branch with load: pc_src deferred two cycles, then high once
      do_reset();
      set_in(2'b11, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0, 32'h80, 5'd1);
      #1 chk("br2_pc_src_c0", {31'h0, pc_src2}, 32'h0);
      chk("br2_target", bt2, 32'h80);
      tick();
      chk("br2_pc_src_c1", {31'h0, pc_src2}, 32'h0);
      tick();
      chk("br2_pc_src_c2", {31'h0, pc_src2}, 32'h1);
      tick();
      chk("br2_pc_src_c3", {31'h0, pc_src2}, 32'h0);
      set_noop();
      #1 chk("br2_pc_src_idle", {31'h0, pc_src2}, 32'h0);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: simulation did not finish, got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
